// File: rtl/div_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_if : EX <-> divider handshake and operand bundle   rev 1.0     |
// +--------------------------------------------------------------------+
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_unit : iterative radix-2 restoring divider with FSM  rev 1.0   |
// +--------------------------------------------------------------------+
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  wire logic clk,
  input  wire logic rst,
  div_if.slave      div_bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     dvs_q, dvs_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  ready_q, ready_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  logic                  w_a_neg, w_b_neg;
  logic [DATA_W-1:0]     w_abs_a, w_abs_b;
  logic [DATA_W:0]       w_shift, w_trial;
  logic [DATA_W-1:0]     w_quo_fix, w_rem_fix;

  assign w_a_neg = div_bus.signed_div_i & div_bus.opdata1_i[DATA_W-1];
  assign w_b_neg = div_bus.signed_div_i & div_bus.opdata2_i[DATA_W-1];
  assign w_abs_a = w_a_neg ? (~div_bus.opdata1_i + 1'b1) : div_bus.opdata1_i;
  assign w_abs_b = w_b_neg ? (~div_bus.opdata2_i + 1'b1) : div_bus.opdata2_i;

  // One extra bit on the trial so a partial remainder near 2**DATA_W cannot wrap.
  assign w_shift = {rem_q, quo_q[DATA_W-1]};
  assign w_trial = w_shift - {1'b0, dvs_q};

  assign w_quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign w_rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = '0;

    case (state_q)
      FREE: begin
        if (div_bus.start_i && !div_bus.annul_i) begin
          if (div_bus.opdata2_i == '0) begin
            state_d = BYZERO;
          end else begin
            state_d   = ON;
            quo_d     = w_abs_a;
            rem_d     = '0;
            dvs_d     = w_abs_b;
            neg_quo_d = w_a_neg ^ w_b_neg;
            neg_rem_d = w_a_neg;
            cnt_d     = '0;
          end
        end
      end
      BYZERO: begin
        if (div_bus.annul_i) begin
          state_d = FREE;
        end else begin
          state_d   = END;
          quo_d     = '0;
          rem_d     = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end
      end
      ON: begin
        if (div_bus.annul_i) begin
          state_d = FREE;
        end else begin
          if (!w_trial[DATA_W]) begin
            rem_d = w_trial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = w_shift[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = END;
          end
        end
      end
      END: begin
        if (div_bus.annul_i || !div_bus.start_i) begin
          state_d = FREE;
        end else begin
          ready_d  = 1'b1;
          result_d = {w_rem_fix, w_quo_fix};
        end
      end
      default: state_d = FREE;
    endcase
  end

  assign div_bus.ready_o  = ready_q;
  assign div_bus.result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_div_unit : directed self-checking bench for div_unit  rev 1.0   |
// +--------------------------------------------------------------------+
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_en = 1'b0;
  bit          expect_idle = 1'b0;
  logic [63:0] exp_result = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Truncating division by plain arithmetic, with the two special cases pinned.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.ready_o !== 1'b1) begin
        check("result_zero_while_not_ready", bus.result_o, 64'd0);
      end else if (expect_idle) begin
        check("ready_after_annul", {63'd0, bus.ready_o}, 64'd0);
      end else begin
        check("result_vs_model", bus.result_o, exp_result);
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_result       = model(a, b, sgn);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input int exp_lat, input logic [63:0] lit, input bit scramble);
    int n;
    @(negedge clk);
    start_op(a, b, sgn);
    n = -1;
    while (1) begin
      @(negedge clk);
      n++;
      if (bus.ready_o === 1'b1 || n > 200) break;
      if (scramble && n == 5) begin
        bus.opdata1_i    = ~a;
        bus.opdata2_i    = b + 32'd3;
        bus.signed_div_i = ~sgn;
      end
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_literal"}, bus.result_o, lit);
    @(negedge clk);
    check({name, "_ready_held"}, {63'd0, bus.ready_o}, 64'd1);
    bus.start_i = 1'b0;
    @(negedge clk);
    check({name, "_ready_drop"}, {63'd0, bus.ready_o}, 64'd0);
  endtask

  task automatic abort_op(input string name, input int at_cycle, input bit use_rst);
    int n;
    @(negedge clk);
    start_op(32'd100, 32'd7, 1'b0);
    expect_idle = 1'b1;
    for (n = 0; n < at_cycle; n++) @(negedge clk);
    bus.start_i = 1'b0;
    if (use_rst) rst = 1'b1;
    else bus.annul_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.annul_i = 1'b0;
    check({name, "_ready"}, {63'd0, bus.ready_o}, 64'd0);
    check({name, "_result"}, bus.result_o, 64'd0);
    repeat (40) @(negedge clk);
    expect_idle = 1'b0;
  endtask

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_op("u100_7",    32'd100,        32'd7,          1'b0, 33, {32'h2, 32'hE}, 1'b0);
    do_op("s_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    do_op("s_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 33, {32'h1, 32'hFFFF_FFFD}, 1'b0);
    do_op("u_m7_2",    32'hFFFF_FFF9,  32'd2,          1'b0, 33, {32'h1, 32'h7FFF_FFFC}, 1'b0);
    do_op("s_m100_m7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 33, {32'hFFFF_FFFE, 32'hE}, 1'b0);
    do_op("divzero",   32'h1234,       32'd0,          1'b0, 2,  64'd0, 1'b0);
    do_op("s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 33, {32'h0, 32'h8000_0000}, 1'b0);
    do_op("u_max_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 33, {32'h0, 32'hFFFF_FFFF}, 1'b0);
    do_op("u_big_3",   32'h8000_0000,  32'd3,          1'b0, 33, {32'h2, 32'h2AAA_AAAA}, 1'b0);

    abort_op("annul_c10", 10, 1'b0);
    do_op("after_annul", 32'd9, 32'd3, 1'b0, 33, {32'h0, 32'h3}, 1'b0);

    abort_op("annul_last", 31, 1'b0);
    abort_op("rst_c20", 20, 1'b1);
    do_op("after_rst", 32'd100, 32'd7, 1'b0, 33, {32'h2, 32'hE}, 1'b0);

    do_op("scramble", 32'd1000, 32'd9, 1'b0, 33, {32'h1, 32'd111}, 1'b1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
